// File: rtl/sr_drive_ctrl.sv
// -----------------------------------------------------------------------------
// sr_drive_ctrl
//
// Drives the S/R inputs of a downstream sr_latch from single-cycle set/clear
// requests. Each accepted request produces one timed pulse on exactly one of
// S or R. After a settle interval the latch outputs are read back and a
// mismatch is flagged. A guard interval follows before the next request is
// accepted.
//
// Sequence per accepted request (cycles after the sampling edge):
//   PULSE  (PULSE_W cycles)  : s_out = target, r_out = !target
//   SETTLE (SETTLE_W cycles) : both drives low
//   CHECK  (1 cycle)         : done = 1, feedback compared against target
//   GAP    (GAP_W cycles)    : both drives low, requests ignored
//
// Optional build macro SR_DRV_SKIP_EN: when defined, a lone request that
// already matches the latch state skips PULSE/SETTLE and goes straight to
// CHECK. When undefined, every accepted request is pulsed.
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous reset, active-high
//   set_req  in   request to set the latch (sampled only in IDLE)
//   clr_req  in   request to clear the latch (sampled only in IDLE)
//   q_fb     in   latch P output
//   qn_fb    in   latch Q output
//   s_out    out  latch S drive, registered
//   r_out    out  latch R drive, registered
//   busy     out  high whenever the controller is not idle
//   done     out  one-cycle pulse in the CHECK cycle
//   err[1:0] out  sticky flags: bit0 request conflict, bit1 feedback mismatch
// -----------------------------------------------------------------------------
module sr_drive_ctrl #(
    parameter int PULSE_W  = 4,
    parameter int SETTLE_W = 3,
    parameter int GAP_W    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       set_req,
    input  logic       clr_req,
    input  logic       q_fb,
    input  logic       qn_fb,
    output logic       s_out,
    output logic       r_out,
    output logic       busy,
    output logic       done,
    output logic [1:0] err
);

    localparam int MAX_W = (PULSE_W > SETTLE_W)
                         ? ((PULSE_W  > GAP_W) ? PULSE_W  : GAP_W)
                         : ((SETTLE_W > GAP_W) ? SETTLE_W : GAP_W);
    localparam int CNT_W = $clog2(MAX_W + 1);

    localparam logic [CNT_W-1:0] PULSE_LD  = CNT_W'(PULSE_W);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_W);
    localparam logic [CNT_W-1:0] GAP_LD    = CNT_W'(GAP_W);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PULSE,
        ST_SETTLE,
        ST_CHECK,
        ST_GAP
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             target_reg, target_next;
    logic             s_reg, s_next;
    logic             r_reg, r_next;
    logic [1:0]       err_set;
    logic             err_flag_reg [2];
    logic             lone_req;
    logic             skip_hit;

    assign lone_req = set_req ^ clr_req;

`ifdef SR_DRV_SKIP_EN
    // A lone request whose target already shows on both latch outputs needs
    // no drive; only the readback check is performed.
    assign skip_hit = lone_req && (set_req ? ( q_fb && !qn_fb)
                                           : (!q_fb &&  qn_fb));
`else
    assign skip_hit = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Next-state and drive logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        target_next = target_reg;
        err_set     = 2'b00;

        case (state_reg)
            ST_IDLE: begin
                if (set_req && clr_req) begin
                    err_set[0] = 1'b1;
                end else if (lone_req) begin
                    target_next = set_req;
                    if (skip_hit) begin
                        state_next = ST_CHECK;
                        cnt_next   = '0;
                    end else begin
                        state_next = ST_PULSE;
                        cnt_next   = PULSE_LD;
                    end
                end
            end
            ST_PULSE: begin
                // The counter holds the number of cycles left in the state,
                // including the current one; leave when it reaches 1.
                if (cnt_reg <= CNT_ONE) begin
                    state_next = ST_SETTLE;
                    cnt_next   = SETTLE_LD;
                end else begin
                    cnt_next = cnt_reg - CNT_ONE;
                end
            end
            ST_SETTLE: begin
                if (cnt_reg <= CNT_ONE) begin
                    state_next = ST_CHECK;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg - CNT_ONE;
                end
            end
            ST_CHECK: begin
                if ((q_fb != target_reg) || (qn_fb != !target_reg)) begin
                    err_set[1] = 1'b1;
                end
                state_next = ST_GAP;
                cnt_next   = GAP_LD;
            end
            ST_GAP: begin
                if (cnt_reg <= CNT_ONE) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg - CNT_ONE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase

        // Drives are registered from the next state so the pulse starts on
        // the accepting edge. Only one of the two can be high because both
        // are gated by the same PULSE term with opposite target polarity.
        s_next = (state_next == ST_PULSE) &&  target_next;
        r_next = (state_next == ST_PULSE) && !target_next;
    end

    // -------------------------------------------------------------------------
    // State, counter, target and drive registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= '0;
            target_reg <= 1'b0;
            s_reg      <= 1'b0;
            r_reg      <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            target_reg <= target_next;
            s_reg      <= s_next;
            r_reg      <= r_next;
        end
    end

    // -------------------------------------------------------------------------
    // Sticky error flags: set-only, cleared only by reset
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_err
            always_ff @(posedge clk) begin
                if (rst) begin
                    err_flag_reg[gi] <= 1'b0;
                end else if (err_set[gi]) begin
                    err_flag_reg[gi] <= 1'b1;
                end
            end
        end
    endgenerate

    assign s_out = s_reg;
    assign r_out = r_reg;
    assign busy  = (state_reg != ST_IDLE);
    assign done  = (state_reg == ST_CHECK);
    assign err   = {err_flag_reg[1], err_flag_reg[0]};

endmodule

// File: doc/sr_drive_ctrl.md
Name: sr_drive_ctrl

Overview:
- Clocked controller that drives the S and R inputs of the downstream sr_latch from single-cycle set/clear requests.
- Each accepted request produces one timed pulse on exactly one of S or R; S and R are never high together.
- After the pulse, the block reads back the latch outputs (P/Q) and flags a mismatch.
- Sits directly upstream of sr_latch: s_out to S, r_out to R, latch P to q_fb, latch Q to qn_fb.

Parameters:
- PULSE_W, 4: cycles s_out/r_out is held high per request (>=1).
- SETTLE_W, 3: cycles both drives low before feedback is checked (>=1).
- GAP_W, 2: cycles both drives low after the check before the next request is accepted (>=1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- set_req  input  1  request to set the latch; sampled only in IDLE.
- clr_req  input  1  request to clear the latch; sampled only in IDLE.
- q_fb  input  1  latch P output.
- qn_fb  input  1  latch Q output.
- s_out  output  1  latch S drive, registered.
- r_out  output  1  latch R drive, registered.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse in the CHECK cycle.
- err  output  2  sticky flags; bit0 = request conflict, bit1 = feedback mismatch.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high, sampled on the rising edge of clk.
- Reset values:
  - s_out = 0, r_out = 0, busy = 0, done = 0, err = 2'b00.
  - state = IDLE, all counters 0, target register 0.
- Reset mid-operation: on the edge where rst = 1, the block returns to IDLE and drops any in-flight pulse; s_out/r_out are low from that edge.
- FSM states: IDLE, PULSE, SETTLE, CHECK, GAP.
- IDLE transitions:
  - set_req xor clr_req: latch target (1 = set, 0 = clear), go to PULSE.
  - Both high: no pulse, err[0] <= 1, stay in IDLE.
  - Neither high: stay in IDLE.
- PULSE: s_out = target, r_out = !target for exactly PULSE_W cycles, then SETTLE.
- SETTLE: both drives 0 for SETTLE_W cycles, then CHECK.
- CHECK (1 cycle):
  - done = 1.
  - Expected feedback is q_fb == target and qn_fb == !target; otherwise err[1] <= 1.
  - Then go to GAP.
- GAP: both drives 0 for GAP_W cycles, then IDLE.
- Timeline, request sampled at edge 0:
  - Drive high in cycles 1..PULSE_W.
  - done in cycle PULSE_W+SETTLE_W+1.
  - IDLE in cycle PULSE_W+SETTLE_W+GAP_W+2; busy is high for every cycle in between.
- Requests while busy: ignored and not queued; err is not affected.
- Invariant: s_out & r_out == 0 in every cycle, including reset and all transitions.
- Counters: width $clog2(max(PULSE_W,SETTLE_W,GAP_W)+1). Each counter reloads on state entry and counts down to 1; no wrap-around is reachable.
- err bits: set-only, cleared only by rst.

Optional Feature:
- Macro: SR_DRV_SKIP_EN.
- Defined: if in IDLE a lone request already matches the latch state (set_req with q_fb=1/qn_fb=0, or clr_req with q_fb=0/qn_fb=1):
  - The block goes straight to CHECK; no drive pulse.
  - done pulses in cycle 1, then GAP; IDLE is reached at cycle GAP_W+2.
- Not defined: every accepted request produces a full pulse regardless of feedback.

Test Plan (defaults PULSE_W=4, SETTLE_W=3, GAP_W=2, model latch attached):
- rst high 2 cycles, then low -> s_out=r_out=busy=done=0, err=00.
- set_req 1 cycle at edge 0 -> s_out=1 in cycles 1-4, r_out=0 throughout; done=1 at cycle 8; busy=1 in cycles 1-10; q_fb=1; err=00.
- clr_req after the set sequence -> r_out=1 for 4 cycles; q_fb=0, qn_fb=1 at CHECK; err=00.
- set_req and clr_req high in the same IDLE cycle -> no drive pulse, busy stays 0, err=01.
- q_fb tied 0, then set_req -> err[1]=1 at cycle 9 and remains 1; set_req held high during busy -> only one pulse; new request accepted at cycle 11.
- rst asserted at cycle 2 of a set pulse -> s_out=0 from that edge, state IDLE, err=00. With SR_DRV_SKIP_EN defined: set_req while q_fb=1 -> no s_out pulse, done at cycle 1.
